// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 frame transmitter.
package spi_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    GAP   = 3'd4,
    HOLD  = 3'd5
  } spi_state_t;

  // Mode 0: sclk rests low between edges and between frames.
  localparam logic SCLK_IDLE = 1'b0;

  // PmodJSTK-style frames are five bytes long.
  localparam int JSTK_BYTES = 5;

  // Largest of four timing values; sizes the shared tick counter.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_output_if.sv
// Request/response and serial pins of the SPI frame transmitter.
// The master side issues frames and models the wire partner; the slave side is the transmitter.
interface spi_output_if #(
  parameter int NBITS = spi_pkg::JSTK_BYTES * 8
);
  logic             start;
  logic [NBITS-1:0] tx_bytes;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] rx_bytes;
  logic             sclk;
  logic             mosi;
  logic             ss_n;
  logic             miso;

  modport master (
    output start, tx_bytes, miso,
    input  busy, done, rx_bytes, sclk, mosi, ss_n
  );

  modport slave (
    input  start, tx_bytes, miso,
    output busy, done, rx_bytes, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_tick_counter.sv
// Loadable down-counter; zero flags the last cycle of the current interval.
// Loading N-1 on entry to a state makes that state last exactly N cycles.
module spi_tick_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end else begin
      count <= count;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/spi_output.sv
// SPI mode-0 master: sends an NBITS word MSB first on mosi while capturing
// miso, with programmable slave-select setup, inter-byte gap and hold times.
module spi_output #(
  parameter int NBITS    = spi_pkg::JSTK_BYTES * 8,
  parameter int CLK_DIV  = 50,
  parameter int SS_SETUP = 1500,
  parameter int BYTE_GAP = 1000,
  parameter int SS_HOLD  = 100
) (
  input logic        clk,
  input logic        rst,
  spi_output_if.slave bus
);
  import spi_pkg::*;

  localparam int CW = $clog2(max_of4(CLK_DIV, SS_SETUP, BYTE_GAP, SS_HOLD)) + 1;
  localparam int BW = $clog2(NBITS + 1);

  spi_state_t       state_q, state_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ss_n_q, ss_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] tx_shift_q, tx_shift_d;
  logic [NBITS-1:0] rx_shift_q, rx_shift_d;
  logic [NBITS-1:0] rx_bytes_q, rx_bytes_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]    bit_inc;
  logic             tick_load;
  logic [CW-1:0]    tick_val;
  logic             tick_zero;

  spi_tick_counter #(.WIDTH(CW)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (tick_load),
    .load_val (tick_val),
    .zero     (tick_zero)
  );

  assign bit_inc = bit_cnt_q + BW'(1);

  // Next-state and next-output logic; every interval ends when the tick counter reaches zero.
  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_bytes_d = rx_bytes_q;
    bit_cnt_d  = bit_cnt_q;
    tick_load  = 1'b0;
    tick_val   = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = SETUP;
          tx_shift_d = bus.tx_bytes;
          rx_shift_d = '0;
          mosi_d     = bus.tx_bytes[NBITS-1];
          ss_n_d     = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          tick_load  = 1'b1;
          tick_val   = CW'(SS_SETUP - 1);
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (tick_zero) begin
          state_d   = LOW;
          sclk_d    = SCLK_IDLE;
          tick_load = 1'b1;
          tick_val  = CW'(CLK_DIV - 1);
        end else begin
          state_d = SETUP;
        end
      end
      LOW: begin
        if (tick_zero) begin
          // Rising sclk edge: capture miso alongside the far end sampling mosi.
          state_d    = HIGH;
          sclk_d     = ~SCLK_IDLE;
          rx_shift_d = {rx_shift_q[NBITS-2:0], bus.miso};
          tick_load  = 1'b1;
          tick_val   = CW'(CLK_DIV - 1);
        end else begin
          state_d = LOW;
        end
      end
      HIGH: begin
        if (tick_zero) begin
          // Falling sclk edge: present the next bit while sclk is low.
          sclk_d     = SCLK_IDLE;
          tx_shift_d = tx_shift_q << 1;
          mosi_d     = tx_shift_q[NBITS-2];
          bit_cnt_d  = bit_inc;
          tick_load  = 1'b1;
          if (bit_inc == BW'(NBITS)) begin
            state_d  = HOLD;
            tick_val = CW'(SS_HOLD - 1);
          end else if (bit_inc[2:0] == 3'd0) begin
            state_d  = GAP;
            tick_val = CW'(BYTE_GAP - 1);
          end else begin
            state_d  = LOW;
            tick_val = CW'(CLK_DIV - 1);
          end
        end else begin
          state_d = HIGH;
        end
      end
      GAP: begin
        if (tick_zero) begin
          state_d   = LOW;
          tick_load = 1'b1;
          tick_val  = CW'(CLK_DIV - 1);
        end else begin
          state_d = GAP;
        end
      end
      HOLD: begin
        if (tick_zero) begin
          state_d    = IDLE;
          ss_n_d     = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_bytes_d = rx_shift_q;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_q     <= SCLK_IDLE;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_bytes_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_bytes_q <= rx_bytes_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.ss_n     = ss_n_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rx_bytes = rx_bytes_q;
endmodule
